// File: rtl/armleocpu_decode.sv
// Decode stage: registers one fetched instruction per cycle toward execute and
// relays execute redirects (branch / FENCE.I flush) back to fetch.
module armleocpu_decode (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        f2d_valid,
  input  logic [1:0]  f2d_type,
  input  logic [31:0] f2d_instr,
  input  logic [31:0] f2d_pc,
  input  logic [3:0]  f2d_resp,

  output logic        d2f_ready,
  output logic [1:0]  d2f_cmd,
  output logic [31:0] d2f_branchtarget,

  output logic        d2e_valid,
  output logic [1:0]  d2e_type,
  output logic [31:0] d2e_instr,
  output logic [31:0] d2e_pc,
  output logic [3:0]  d2e_resp,
  output logic [4:0]  d2e_rd,
  output logic [4:0]  d2e_rs1,
  output logic [4:0]  d2e_rs2,

  input  logic        e2d_ready,
  input  logic        e2d_start_branch,
  input  logic        e2d_flush,
  input  logic [31:0] e2d_branchtarget,

  output logic        dbg_pipeline_busy
);

  localparam logic [1:0] F2E_TYPE_INTERRUPT_PENDING = 2'd1;
  localparam logic [1:0] D2F_CMD_NONE               = 2'd0;
  localparam logic [1:0] D2F_CMD_START_BRANCH       = 2'd1;
  localparam logic [1:0] D2F_CMD_FLUSH              = 2'd2;
  localparam logic [3:0] CACHE_RESPONSE_SUCCESS     = 4'd0;
  localparam logic [6:0] OPCODE_SYSTEM              = 7'b1110011;
  localparam logic [6:0] OPCODE_MISC_MEM            = 7'b0001111;

  typedef enum logic {RUN, WAIT_EXEC} state_t;
  state_t state_reg;

  logic redirect;
  logic free;
  logic load;
  logic serializing;

  assign redirect = e2d_flush || e2d_start_branch;
  assign free     = !d2e_valid || e2d_ready;

  // Anything whose effect on architectural state execute must resolve first
  assign serializing = (f2d_type == F2E_TYPE_INTERRUPT_PENDING)
                    || (f2d_resp != CACHE_RESPONSE_SUCCESS)
                    || (f2d_instr[6:0] == OPCODE_SYSTEM)
                    || (f2d_instr[6:0] == OPCODE_MISC_MEM);

  always_comb begin
    d2f_cmd          = D2F_CMD_NONE;
    d2f_branchtarget = 32'd0;
    if (state_reg == WAIT_EXEC)
      d2f_ready = !f2d_valid;
    else
      d2f_ready = free;
    if (e2d_flush) begin
      d2f_cmd          = D2F_CMD_FLUSH;
      d2f_ready        = 1'b1;
      d2f_branchtarget = e2d_branchtarget;
    end else if (e2d_start_branch) begin
      d2f_cmd          = D2F_CMD_START_BRANCH;
      d2f_ready        = 1'b1;
      d2f_branchtarget = e2d_branchtarget;
    end
  end

  assign load = (state_reg == RUN) && f2d_valid && free && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      d2e_valid <= 1'b0;
      d2e_type  <= 2'd0;
      d2e_instr <= 32'd0;
      d2e_pc    <= 32'd0;
      d2e_resp  <= 4'd0;
      d2e_rd    <= 5'd0;
      d2e_rs1   <= 5'd0;
      d2e_rs2   <= 5'd0;
    end else if (redirect) begin
      // The held instruction is younger than the redirecting one: kill it
      state_reg <= RUN;
      d2e_valid <= 1'b0;
    end else if (load) begin
      d2e_valid <= 1'b1;
      d2e_type  <= f2d_type;
      d2e_instr <= f2d_instr;
      d2e_pc    <= f2d_pc;
      d2e_resp  <= f2d_resp;
      d2e_rd    <= f2d_instr[11:7];
      d2e_rs1   <= f2d_instr[19:15];
      d2e_rs2   <= f2d_instr[24:20];
      if (serializing)
        state_reg <= WAIT_EXEC;
    end else if (e2d_ready && d2e_valid) begin
      d2e_valid <= 1'b0;
    end
  end

  assign dbg_pipeline_busy = d2e_valid || (state_reg == WAIT_EXEC);

endmodule
